uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (tx_data/tx_send/tx_full interface of the uart block) among N_REQ byte-stream requesters.
- Arbitration is packet-atomic and round-robin. A grant is held from the first byte until req_last, or until MAX_PKT bytes have been sent.
- Sits between on-chip producers (echo path, status reporter, debug dump) and the uart instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_PKT, 64, maximum bytes per grant before forced release (1..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk
- req_valid  in  N_REQ  requester i has a byte on req_data[8i+7:8i]
- req_data  in  8*N_REQ  packed byte per requester
- req_last  in  N_REQ  byte on requester i is the final byte of its packet
- req_ready  out  N_REQ  byte from requester i accepted this cycle (combinational)
- tx_full  in  1  UART TX buffer full
- tx_data  out  8  byte to UART (registered)
- tx_send  out  1  one-cycle push strobe to UART (registered)
- grant  out  N_REQ  one-hot current owner; 0 when idle (registered)
- busy  out  1  grant held (registered)
- trunc  out  1  one-cycle pulse on forced release at MAX_PKT (registered)

Behaviour:
- Reset (rst_n=0 at posedge), also when it arrives mid-packet:
  - tx_data=0, tx_send=0, grant=0, busy=0, trunc=0, byte count=0, state=IDLE.
  - RR pointer = N_REQ-1, so requester 0 has first priority.
  - A byte already pushed stays in the UART; the packet is abandoned.
- States: IDLE, TAG (present only with the optional feature), XFER.
- IDLE:
  - Stays in IDLE if req_valid==0.
  - Otherwise grants the first requester with valid set, searching from pointer+1 upward modulo N_REQ.
  - Next cycle: grant/busy asserted, state=XFER (or TAG), count=0. No byte is accepted in the IDLE cycle.
- Push slot: tx_full==0 and tx_send==0. The tx_send==0 term guarantees one idle cycle between strobes so tx_full can update.
- XFER accept, for owner g: req_ready[g] = req_valid[g] & push slot. All other req_ready bits are 0.
- On accept at cycle t:
  - tx_data <= byte and tx_send <= 1, both visible in cycle t+1; tx_send is deasserted in t+2.
  - Peak throughput is 1 byte per 2 cycles.
  - count <= count+1.
- Release on accept with req_last[g]=1:
  - state <= IDLE, grant <= 0, busy <= 0, pointer <= g.
- Release on accept with count+1 == MAX_PKT and req_last=0:
  - Same release as req_last, plus trunc pulses one cycle.
  - The requester's remaining bytes re-arbitrate as a new packet.
- req_last and MAX_PKT on the same byte: normal release, no trunc.
- Owner deasserts req_valid mid-packet: the grant is held indefinitely and no other requester is served.
- tx_full high: no accept; bytes are never dropped. Stall any number of cycles.
- Single requester continuously valid: it is re-granted after one IDLE cycle per packet.
- Width rule: count is $clog2(MAX_PKT+1) bits and never wraps, because release occurs at MAX_PKT.

Optional Feature:
- Macro: UART_ARB_TAG_EN.
- Defined:
  - After a grant, state TAG pushes one header byte 8'h30+g (ASCII digit of the requester index) using the same push-slot rule, with req_ready=0.
  - Then XFER. The tag does not count toward MAX_PKT.
- Undefined: TAG state and its logic are absent; IDLE goes straight to XFER.

Decomposition:
- Package uart_arb_pkg:
  - State enum (IDLE/TAG/XFER).
  - TAG_BASE = 8'h30.
  - Helper function for the byte-lane slice of req_data.
- Sub-module rr_arbiter (combinational):
  - Inputs: req vector and pointer.
  - Output: one-hot winner plus any-valid flag.
  - Reusable by other shared-resource controllers.

Test Plan:
- Reset, then req_valid=4'b0001 with 3 bytes 0x41,0x42,0x43 (last on 0x43), tx_full=0 -> tx_send strobes every 2nd cycle with data 41,42,43; grant=0001 throughout; busy drops the cycle after the 0x43 accept.
- req_valid=4'b1111 with every requester sending 1-byte packets repeatedly -> grants in order 0,1,2,3,0; no requester served twice before all others.
- tx_full held high for 10 cycles mid-packet -> req_ready=0 and no tx_send during the stall; byte order intact afterwards; no drops.
- MAX_PKT=4, requester 2 sends 6 bytes with last on byte 6 -> trunc pulses after byte 4; requester 2 re-granted (sole requester) for bytes 5-6; total 6 strobes.
- rst_n low for 1 cycle after byte 2 of a 5-byte packet -> all outputs 0 the next cycle; the next grant goes to the lowest-index valid requester.
- With UART_ARB_TAG_EN, requester 3 sends 0x55 (last) -> strobes with 0x33 then 0x55.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types, constants and helpers for the UART TX arbiter
package uart_arb_pkg;
    typedef enum logic [1:0] {IDLE, TAG, XFER} arb_state_t;
    localparam logic [7:0] TAG_BASE = 8'h30;
    function automatic logic [7:0] lane(input logic [63:0] data, input int unsigned idx);
        return data[idx*8 +: 8];
    endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte streams, UART push port and arbiter status
interface uart_tx_arbiter_if #(parameter int N_REQ = 4);
    logic [N_REQ-1:0] req_valid, req_last, req_ready, grant;
    logic [8*N_REQ-1:0] req_data;
    logic tx_full, tx_send, busy, trunc;
    logic [7:0] tx_data;
    modport master (
        input  req_valid, req_data, req_last, tx_full,
        output req_ready, tx_data, tx_send, grant, busy, trunc
    );
    modport slave (
        output req_valid, req_data, req_last, tx_full,
        input  req_ready, tx_data, tx_send, grant, busy, trunc
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr+1
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic                 any
);
    int j;
    assign any = |req;
    // Scan from farthest to nearest so the candidate just after ptr wins
    always_comb begin
        gnt = '0;
        j = 0;
        for (int k = N; k >= 1; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) gnt = N'(1) << j;
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-atomic round-robin sharing of one UART TX; UART_ARB_TAG_EN adds an ASCII owner-tag byte per grant
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MAX_PKT = 64
) (
    input logic clk,
    input logic rst_n,
    uart_tx_arbiter_if.master bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_PKT + 1);
    arb_state_t state;
    logic [IW-1:0] ptr, own, win_idx;
    logic [CW-1:0] cnt;
    logic [N_REQ-1:0] win;
    logic any, slot, acc, done;
    rr_arbiter #(.N(N_REQ)) u_rr (.req(bus.req_valid), .ptr(ptr), .gnt(win), .any(any));
    always_comb begin
        win_idx = '0;
        for (int k = 0; k < N_REQ; k++) if (win[k]) win_idx = IW'(k);
    end
    // tx_send must be low so the UART has a cycle to update tx_full
    assign slot = !bus.tx_full && !bus.tx_send;
    assign acc = state == XFER && bus.req_valid[own] && slot;
    assign done = bus.req_last[own] || cnt == CW'(MAX_PKT - 1);
    assign bus.req_ready = acc ? bus.grant : '0;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= IW'(N_REQ - 1);
            own         <= '0;
            cnt         <= '0;
            bus.tx_data <= '0;
            bus.tx_send <= 1'b0;
            bus.grant   <= '0;
            bus.busy    <= 1'b0;
            bus.trunc   <= 1'b0;
        end else begin
            bus.tx_send <= 1'b0;
            bus.trunc   <= 1'b0;
            case (state)
                IDLE: if (any) begin
                    own       <= win_idx;
                    bus.grant <= win;
                    bus.busy  <= 1'b1;
                    cnt       <= '0;
`ifdef UART_ARB_TAG_EN
                    state     <= TAG;
`else
                    state     <= XFER;
`endif
                end
`ifdef UART_ARB_TAG_EN
                TAG: if (slot) begin
                    bus.tx_data <= TAG_BASE + 8'(own);
                    bus.tx_send <= 1'b1;
                    state       <= XFER;
                end
`endif
                XFER: if (acc) begin
                    bus.tx_data <= lane(64'(bus.req_data), int'(own));
                    bus.tx_send <= 1'b1;
                    cnt         <= cnt + 1'b1;
                    if (done) begin
                        state     <= IDLE;
                        bus.grant <= '0;
                        bus.busy  <= 1'b0;
                        ptr       <= own;
                        bus.trunc <= !bus.req_last[own];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scoreboard bench for uart_tx_arbiter (N_REQ=4, MAX_PKT=4)
module tb_uart_tx_arbiter;
    localparam int N = 4;
`ifdef UART_ARB_TAG_EN
    localparam int TG = 1;
`else
    localparam int TG = 0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    uart_tx_arbiter_if #(.N_REQ(N)) bus ();
    uart_tx_arbiter #(.N_REQ(N), .MAX_PKT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    logic [8:0] src [N][$];
    logic [7:0] exp_q [$];
    logic [N-1:0] last_rdy;
    logic last_send;
    int checks = 0, errors = 0, n_send = 0, n_trunc = 0, trunc_at = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i] = src[i].size() > 0;
            bus.req_data[i*8 +: 8] = src[i].size() > 0 ? src[i][0][7:0] : 8'h00;
            bus.req_last[i] = src[i].size() > 0 ? src[i][0][8] : 1'b0;
        end
    endtask

    task automatic add(input int r, input logic [7:0] b, input logic l);
        src[r].push_back({l, b});
        exp_q.push_back(b);
    endtask

    task automatic hdr(input int r);
        if (TG != 0) exp_q.push_back(8'h30 + 8'(r));
    endtask

    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        last_rdy = rst_n ? bus.req_ready : '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (last_rdy[i] && src[i].size() > 0) void'(src[i].pop_front());
        drive();
        last_send = bus.tx_send;
        if (bus.tx_send) begin
            n_send++;
            if (exp_q.size() > 0) e = 32'(exp_q.pop_front());
            else e = 32'hdead;
            chk("tx_data", 32'(bus.tx_data), e);
        end
        if (bus.trunc) begin
            n_trunc++;
            trunc_at = n_send;
        end
    endtask

    function automatic bit quiet();
        for (int i = 0; i < N; i++) if (src[i].size() > 0) return 1'b0;
        return exp_q.size() == 0 && !bus.busy && !bus.tx_send;
    endfunction

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (n < budget && !quiet()) begin
            tick();
            n++;
        end
        chk(tag, 32'(quiet()), 32'd1);
    endtask

    task automatic wait_sends(input string tag, input int target, input int budget);
        int n = 0;
        while (n < budget && n_send < target) begin
            tick();
            n++;
        end
        chk(tag, 32'(n_send >= target), 32'd1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_send"}, 32'(bus.tx_send), 32'd0);
        chk({tag, "_data"}, 32'(bus.tx_data), 32'd0);
        chk({tag, "_grant"}, 32'(bus.grant), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_trunc"}, 32'(bus.trunc), 32'd0);
    endtask

    initial begin
        int s0, t0;
        bus.tx_full = 1'b0;
        drive();
        tick();
        tick();
        chk_idle_outputs("reset");
        rst_n = 1'b1;

        // single packet from requester 0: strobe every second cycle
        add(0, 8'h41, 1'b0);
        add(0, 8'h42, 1'b0);
        add(0, 8'h43, 1'b1);
        exp_q.delete();
        hdr(0);
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h43);
        drive();
        for (int k = 1; k <= 7 + 2 * TG; k++) begin
            tick();
            chk("p1_send", 32'(bus.tx_send), 32'(k % 2 == 0 && k <= 6 + 2 * TG));
            chk("p1_busy", 32'(bus.busy), 32'(k <= 5 + 2 * TG));
            chk("p1_grant", 32'(bus.grant), k <= 5 + 2 * TG ? 32'd1 : 32'd0);
        end

        // round robin over all four after a fresh reset
        rst_n = 1'b0;
        tick();
        chk_idle_outputs("rst2");
        rst_n = 1'b1;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++) begin
                src[i].push_back({1'b1, 8'hA0 + 8'(16 * p + i)});
                hdr(i);
                exp_q.push_back(8'hA0 + 8'(16 * p + i));
            end
        drive();
        drain("rr_drain", 200);

        // req_last coinciding with MAX_PKT: no trunc
        t0 = n_trunc;
        hdr(0);
        for (int b = 0; b < 4; b++) add(0, 8'h51 + 8'(b), b == 3);
        drive();
        drain("max_last_drain", 100);
        chk("max_last_trunc", 32'(n_trunc - t0), 32'd0);

        // tx_full stall mid-packet
        hdr(1);
        add(1, 8'h61, 1'b0);
        add(1, 8'h62, 1'b0);
        add(1, 8'h63, 1'b1);
        drive();
        s0 = n_send;
        wait_sends("stall_first", s0 + 1 + TG, 50);
        bus.tx_full = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("stall_rdy", 32'(last_rdy), 32'd0);
            chk("stall_send", 32'(last_send), 32'd0);
        end
        bus.tx_full = 1'b0;
        drain("stall_drain", 100);
        chk("stall_count", 32'(n_send - s0), 32'(3 + TG));

        // forced release at MAX_PKT, remainder re-granted
        s0 = n_send;
        t0 = n_trunc;
        hdr(2);
        for (int b = 0; b < 4; b++) add(2, 8'h71 + 8'(b), 1'b0);
        hdr(2);
        add(2, 8'h75, 1'b0);
        add(2, 8'h76, 1'b1);
        drive();
        drain("trunc_drain", 100);
        chk("trunc_count", 32'(n_trunc - t0), 32'd1);
        chk("trunc_pos", 32'(trunc_at - s0), 32'(4 + TG));
        chk("trunc_sends", 32'(n_send - s0), 32'(6 + 2 * TG));

        // reset mid-packet abandons it; lowest valid index wins next
        s0 = n_send;
        hdr(3);
        for (int b = 0; b < 5; b++) add(3, 8'h81 + 8'(b), b == 4);
        drive();
        wait_sends("rstmid_wait", s0 + 2, 50);
        rst_n = 1'b0;
        tick();
        chk_idle_outputs("rstmid");
        exp_q.delete();
        src[1].push_back({1'b1, 8'h91});
        hdr(1);
        exp_q.push_back(8'h91);
        hdr(3);
        if (TG != 0) exp_q.push_back(8'h82);
        exp_q.push_back(8'h83);
        exp_q.push_back(8'h84);
        exp_q.push_back(8'h85);
        rst_n = 1'b1;
        drive();
        tick();
        chk("rstmid_regrant", 32'(bus.grant), 32'h2);
        drain("rstmid_drain", 100);

        // one-byte packet from requester 3 (tagged build prefixes '3')
        s0 = n_send;
        hdr(3);
        add(3, 8'h55, 1'b1);
        drive();
        drain("tag_drain", 50);
        chk("tag_sends", 32'(n_send - s0), 32'(1 + TG));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
